// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, header layout and packet sequencer states.
// Imported by the packet controller and the byte-mask helper.
package csi2_pkg;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;
    localparam logic [5:0] DT_RAW8      = 6'h2A;
    localparam logic [5:0] DT_RAW10     = 6'h2B;

    localparam int HDR_BYTES   = 4;
    localparam int HDR_DI_OFS  = 0;
    localparam int HDR_WCL_OFS = 1;
    localparam int HDR_WCH_OFS = 2;
    localparam int HDR_ECC_OFS = 3;
    localparam int CRC_BYTES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_EOP     = 2'd3
    } pkt_state_e;

    function automatic logic is_short_dt(input logic [5:0] dt);
        return (dt <= DT_SHORT_MAX);
    endfunction

endpackage

// File: rtl/csi2_packet_ctrl_if.sv
// Byte-enabled payload stream from the packet controller to the pixel unpacker.
interface csi2_packet_ctrl_if #(
    parameter int LANES = 2
);
    logic [8*LANES-1:0] pld_data;
    logic [LANES-1:0]   pld_be;
    logic               pld_valid;
    logic               pld_last;

    modport master (output pld_data, output pld_be, output pld_valid, output pld_last);
    modport slave  (input  pld_data, input  pld_be, input  pld_valid, input  pld_last);
endinterface

// File: rtl/csi2_byte_mask.sv
// Splits one beat of a packet body into bytes consumed, payload bytes and their enables,
// given the bytes still outstanding (payload plus CRC footer).
module csi2_byte_mask
    import csi2_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [16:0]      rem,
    output logic [2:0]       take,
    output logic [2:0]       pay_cnt,
    output logic [LANES-1:0] be,
    output logic             last
);
    localparam logic [16:0] LANES_W = 17'(LANES);
    localparam logic [16:0] CRC_W   = 17'(CRC_BYTES);

    logic [16:0] pay_rem_s;

    // byte accounting for the current beat; footer bytes never count as payload
    always_comb begin
        take      = 3'd0;
        pay_cnt   = 3'd0;
        be        = '0;
        last      = 1'b0;
        pay_rem_s = 17'd0;
        if (rem >= LANES_W) begin
            take = LANES_W[2:0];
        end else begin
            take = rem[2:0];
        end
        if (rem > CRC_W) begin
            pay_rem_s = rem - CRC_W;
        end else begin
            pay_rem_s = 17'd0;
        end
        if (pay_rem_s >= {14'd0, take}) begin
            pay_cnt = take;
        end else begin
            pay_cnt = pay_rem_s[2:0];
        end
        for (int i = 0; i < LANES; i++) begin
            be[i] = (3'(i) < pay_cnt);
        end
        last = (pay_rem_s != 17'd0) && (pay_rem_s <= LANES_W);
    end
endmodule

// File: rtl/csi2_packet_ctrl.sv
// CSI-2 packet sequencer: parses headers, streams long-packet payload without the CRC,
// raises frame/line events and tells the aligner when a packet has been fully consumed.
module csi2_packet_ctrl
    import csi2_pkg::*;
#(
    parameter int          LANES      = 2,
    parameter int          DATA_WIDTH = 8*LANES,
    parameter logic [1:0]  VC_SEL     = 2'd0,
    parameter logic [15:0] MAX_WC     = 16'd8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] aligned_data,
    input  logic                  rx_valid,
    output logic                  end_of_packet,
    csi2_packet_ctrl_if.master    pld,
    output logic [5:0]            pkt_dt,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  line_start,
    output logic                  hdr_err
);
    localparam int HB = HDR_BYTES / LANES;

    pkt_state_e state_r, state_s;
    logic [16:0] rem_r, rem_s;
    logic [1:0]  vc_r, vc_s;
    logic [5:0]  dt_r, dt_s;
    logic        blocked_r, blocked_s;
    logic        hdr_load_s, hdr_done_s;
    logic [DATA_WIDTH-1:0] pld_data_r, pld_data_s;
    logic [LANES-1:0]      pld_be_r, pld_be_s;
    logic        pld_valid_r, pld_valid_s, pld_last_r, pld_last_s;
    logic        eop_r, eop_s, fs_r, fs_s, fe_r, fe_s, ls_r, ls_s, err_r, err_s;

    logic [31:0] hdr_word_s;
    logic [7:0]  di_s;
    logic [15:0] wc_s;
    logic [7:0]  unused_ecc_s;
    logic        vc_ok_s;
    logic [2:0]  take_s, pay_cnt_s;
    logic [LANES-1:0] be_s;
    logic        last_s;

    generate
        if (HB > 1) begin : g_hdr_two_beat
            logic [15:0] hdr_r;
            // first header beat (DI, WC_L) is held until the second beat completes it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hdr_r <= 16'd0;
                end else if (hdr_load_s) begin
                    hdr_r <= aligned_data[15:0];
                end else begin
                    hdr_r <= hdr_r;
                end
            end
            assign hdr_word_s = {aligned_data[15:0], hdr_r};
        end else begin : g_hdr_one_beat
            logic unused_hdr_load_s;
            assign unused_hdr_load_s = hdr_load_s;
            assign hdr_word_s        = aligned_data[31:0];
        end
    endgenerate

    assign di_s         = hdr_word_s[8*HDR_DI_OFS +: 8];
    assign wc_s         = {hdr_word_s[8*HDR_WCH_OFS +: 8], hdr_word_s[8*HDR_WCL_OFS +: 8]};
    assign unused_ecc_s = hdr_word_s[8*HDR_ECC_OFS +: 8];
    assign vc_ok_s      = (di_s[7:6] == VC_SEL);

    csi2_byte_mask #(.LANES(LANES)) u_byte_mask (
        .rem     (rem_r),
        .take    (take_s),
        .pay_cnt (pay_cnt_s),
        .be      (be_s),
        .last    (last_s)
    );

    // next-state and next-output logic; outputs are registered below
    always_comb begin
        state_s     = state_r;
        rem_s       = rem_r;
        vc_s        = vc_r;
        dt_s        = dt_r;
        blocked_s   = blocked_r;
        hdr_load_s  = 1'b0;
        hdr_done_s  = 1'b0;
        pld_data_s  = '0;
        pld_be_s    = '0;
        pld_valid_s = 1'b0;
        pld_last_s  = 1'b0;
        fs_s        = 1'b0;
        fe_s        = 1'b0;
        ls_s        = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && !blocked_r) begin
                    if (HB > 1) begin
                        hdr_load_s = 1'b1;
                        state_s    = ST_HDR;
                    end else begin
                        hdr_done_s = 1'b1;
                    end
                end else if (!rx_valid) begin
                    blocked_s = 1'b0;
                end else begin
                    blocked_s = blocked_r;
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    hdr_done_s = 1'b1;
                end else begin
                    hdr_done_s = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    rem_s = rem_r - {14'd0, take_s};
                    if ((pay_cnt_s != 3'd0) && (vc_r == VC_SEL)) begin
                        pld_valid_s = 1'b1;
                        pld_be_s    = be_s;
                        pld_data_s  = aligned_data;
                        pld_last_s  = last_s;
                    end else begin
                        pld_valid_s = 1'b0;
                    end
                    if (rem_s == 17'd0) begin
                        state_s = ST_EOP;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_EOP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (hdr_done_s) begin
            dt_s = di_s[5:0];
            vc_s = di_s[7:6];
            if (is_short_dt(di_s[5:0])) begin
                state_s = ST_EOP;
                fs_s    = vc_ok_s && (di_s[5:0] == DT_FS);
                fe_s    = vc_ok_s && (di_s[5:0] == DT_FE);
                ls_s    = vc_ok_s && (di_s[5:0] == DT_LS);
            end else if ((wc_s == 16'd0) || (wc_s > MAX_WC)) begin
                err_s   = 1'b1;
                state_s = ST_EOP;
            end else begin
                rem_s   = {1'b0, wc_s} + 17'(CRC_BYTES);
                state_s = ST_PAYLOAD;
            end
        end else begin
            err_s = 1'b0;
        end
        // stale aligner data is ignored until rx_valid drops after the packet
        eop_s     = (state_s == ST_EOP);
        blocked_s = blocked_s | eop_s;
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= 17'd0;
            vc_r        <= 2'd0;
            dt_r        <= 6'd0;
            blocked_r   <= 1'b0;
            pld_data_r  <= '0;
            pld_be_r    <= '0;
            pld_valid_r <= 1'b0;
            pld_last_r  <= 1'b0;
            eop_r       <= 1'b0;
            fs_r        <= 1'b0;
            fe_r        <= 1'b0;
            ls_r        <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            rem_r       <= rem_s;
            vc_r        <= vc_s;
            dt_r        <= dt_s;
            blocked_r   <= blocked_s;
            pld_data_r  <= pld_data_s;
            pld_be_r    <= pld_be_s;
            pld_valid_r <= pld_valid_s;
            pld_last_r  <= pld_last_s;
            eop_r       <= eop_s;
            fs_r        <= fs_s;
            fe_r        <= fe_s;
            ls_r        <= ls_s;
            err_r       <= err_s;
        end
    end

    assign pld.pld_data   = pld_data_r;
    assign pld.pld_be     = pld_be_r;
    assign pld.pld_valid  = pld_valid_r;
    assign pld.pld_last   = pld_last_r;
    assign end_of_packet  = eop_r;
    assign pkt_dt         = dt_r;
    assign frame_start    = fs_r;
    assign frame_end      = fe_r;
    assign line_start     = ls_r;
    assign hdr_err        = err_r;
endmodule

// File: doc/csi2_packet_ctrl.md
Name: csi2_packet_ctrl

Overview:
- Sequences the per-lane-aligned CSI-2 byte stream leaving data_aligner.
- Parses each packet header and counts out the long-packet payload, then strips the CRC footer.
- Returns end_of_packet to the aligner so it re-hunts the next sync word.
- Emits a byte-enabled payload stream plus frame/line event pulses to the downstream pixel unpacker.

Parameters:
- LANES, 2, number of D-PHY lanes; legal values 2 or 4.
- DATA_WIDTH, 8*LANES, width of the aligned data bus; byte 0 = bits [7:0] = earliest byte.
- VC_SEL, 0, virtual channel accepted (2 bits); packets on other VCs are consumed, no output.
- MAX_WC, 16'd8192, largest legal long-packet word count; larger values are header errors.

Ports:
- clk  in  1  pixel-side byte clock, same clock as data_aligner
- rst_n  in  1  asynchronous active-low reset
- aligned_data  in  DATA_WIDTH  aligned bytes from data_aligner
- rx_valid  in  1  aligned_data valid; qualifies every beat
- end_of_packet  out  1  one-cycle pulse to data_aligner: packet fully consumed, re-align
- pld_data  out  DATA_WIDTH  payload bytes, same byte order as input
- pld_be  out  LANES  byte enables for pld_data; contiguous from bit 0
- pld_valid  out  1  payload beat valid
- pld_last  out  1  last payload beat of the packet
- pkt_dt  out  6  data type of the current or last packet; held until the next header
- frame_start  out  1  pulse on short packet DT 0x00
- frame_end  out  1  pulse on short packet DT 0x01
- line_start  out  1  pulse on short packet DT 0x02
- hdr_err  out  1  pulse: WC > MAX_WC on a long packet, or WC == 0 on a long packet

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including pkt_dt, counters and header shift register.
- Header: 4 bytes (DI, WC_L, WC_H, ECC) spread over HB = 4/LANES beats (2 beats at 2 lanes, 1 beat at 4 lanes). ECC is not checked.
- DI decode: VC = DI[7:6], DT = DI[5:0]. DT <= 0x0F is a short packet; anything else is a long packet.
- IDLE: the first beat with rx_valid=1 loads header byte(s). Go to HDR if HB > 1, else decode in the same cycle.
- HDR: collect the remaining header bytes on valid beats only. On the final header byte:
  - Short packet: go to EOP.
  - Long packet, bad WC: pulse hdr_err, go to EOP.
  - Long packet, otherwise: load rem = WC + 2 (17-bit; the +2 covers the CRC footer) and go to PAYLOAD.
- PAYLOAD, each valid beat:
  - take n = min(LANES, rem) bytes; rem -= n.
  - payload bytes in the beat = min(n, max(rem_before - 2, 0)); pld_be = that many ones from bit 0.
  - pld_valid = 1 only if the payload-byte count is > 0 and VC == VC_SEL.
  - pld_last = 1 on the beat carrying the final payload byte.
  - when rem reaches 0, go to EOP.
- Footer-only beats (payload already exhausted, CRC bytes remain) give pld_valid = 0.
- EOP:
  - end_of_packet = 1 for exactly one cycle.
  - short-packet event pulses (gated by VC == VC_SEL) are issued in this same cycle. DT 0x03 (line end) and others produce no pulse.
  - next cycle → IDLE.
  - aligned_data is ignored in EOP and until rx_valid is seen low for ≥1 cycle after EOP; this guards against stale aligner output.
- rx_valid low mid-HDR or mid-PAYLOAD: stall with no state change and no output. The packet is never aborted by a gap.
- Registered outputs: pld_* appear 1 cycle after the input beat; event pulses appear 1 cycle after the final header byte.
- pkt_dt updates on header decode, including for filtered VCs.
- Reset asserted mid-packet: immediate return to IDLE with all outputs 0; no end_of_packet is issued.

Decomposition:
- Shared package csi2_pkg holds:
  - DT constants: DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03, DT_SHORT_MAX=0x0F, DT_RAW8=0x2A, DT_RAW10=0x2B.
  - header byte offsets.
  - state encoding: IDLE, HDR, PAYLOAD, EOP.
- One natural sub-module, csi2_byte_mask: combinational; maps (rem_before, LANES) to n and pld_be. It is reused by the later pixel unpacker.

Test Plan:
- LANES=2, long RAW8 packet, VC 0, WC=5:
  - header beats {0x2A,0x05},{0x00,ECC}, then 3 payload/CRC beats {d0,d1},{d2,d3},{d4,C0} and a fourth beat {C1,x}.
  - required: pld_valid on 3 beats with be 11,11,01; pld_last on the third; 4th beat pld_valid=0; end_of_packet 1 cycle after it.
- LANES=4, short FS packet {0x00,0x01,0x00,ECC} → frame_start=1 for one cycle, coincident with end_of_packet; no pld_valid.
- LANES=2, long packet WC=4 with rx_valid low for 3 cycles mid-payload → identical output sequence, delayed 3 cycles; exactly one end_of_packet.
- VC=1 long packet, VC_SEL=0, WC=8 → no pld_valid, pkt_dt=0x2A, end_of_packet after 5 payload+CRC beats (LANES=2).
- Long packet with WC=0 → hdr_err pulse, end_of_packet next, back in IDLE. WC=0x4000 with MAX_WC=8192 → same response.
- rst_n low while in PAYLOAD with rem=6 → all outputs 0 asynchronously. After release, a new FE short packet yields a frame_end pulse with no leftover payload beats.
